// File: rtl/match_sequencer.sv
// Match-level controller for pong: sequences idle, serve countdown, rally,
// pause, scoring and game-over, and drives the launch strobe and score display.
module match_sequencer #(
  parameter int WIN_SCORE    = 7,
  parameter int SERVE_FRAMES = 60,
  parameter int OVER_FRAMES  = 180,
  parameter int SCORE_W      = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_clk,
  input  logic               start_button,
  input  logic               pause_button,
  input  logic               point_left,
  input  logic               point_right,
  output logic               start_game,
  output logic               ball_hold,
  output logic               serve_dir,
  output logic [SCORE_W-1:0] score_left,
  output logic [SCORE_W-1:0] score_right,
  output logic [1:0]         winner,
  output logic [2:0]         match_state,
  output logic [7:0]         countdown
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SERVE = 3'd1;
  localparam logic [2:0] S_PLAY  = 3'd2;
  localparam logic [2:0] S_PAUSE = 3'd3;
  localparam logic [2:0] S_OVER  = 3'd4;

  localparam logic [SCORE_W-1:0] WIN_VAL   = SCORE_W'(WIN_SCORE);
  localparam logic [7:0]         SERVE_LD  = 8'(SERVE_FRAMES);
  localparam logic [7:0]         OVER_LD   = 8'(OVER_FRAMES);

  logic start_q;
  logic pause_q;
  logic start_edge;
  logic pause_edge;
  logic [SCORE_W-1:0] left_next;
  logic [SCORE_W-1:0] right_next;

  assign start_edge = start_button & ~start_q;
  assign pause_edge = pause_button & ~pause_q;
  assign left_next  = score_left + 1'b1;
  assign right_next = score_right + 1'b1;
  assign ball_hold  = (match_state != S_PLAY);

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // History resets high so a button held through reset cannot fire.
      start_q     <= 1'b1;
      pause_q     <= 1'b1;
      match_state <= S_IDLE;
      start_game  <= 1'b0;
      serve_dir   <= 1'b1;
      score_left  <= '0;
      score_right <= '0;
      winner      <= 2'b00;
      countdown   <= 8'd0;
    end else begin
      start_q    <= start_button;
      pause_q    <= pause_button;
      start_game <= 1'b0;
      case (match_state)
        S_IDLE: begin
          if (start_edge) begin
            score_left  <= '0;
            score_right <= '0;
            winner      <= 2'b00;
            serve_dir   <= 1'b1;
            countdown   <= SERVE_LD;
            match_state <= S_SERVE;
          end
        end
        S_SERVE: begin
          if (frame_clk) begin
            if (countdown == 8'd1) begin
              countdown   <= 8'd0;
              start_game  <= 1'b1;
              match_state <= S_PLAY;
            end else begin
              countdown <= countdown - 8'd1;
            end
          end
        end
        S_PLAY: begin
          // Points take priority over a same-cycle pause edge.
          if (point_left && point_right) begin
            countdown   <= SERVE_LD;
            match_state <= S_SERVE;
          end else if (point_left) begin
            score_left <= left_next;
            serve_dir  <= 1'b1;
            if (left_next == WIN_VAL) begin
              winner      <= 2'b01;
              countdown   <= OVER_LD;
              match_state <= S_OVER;
            end else begin
              countdown   <= SERVE_LD;
              match_state <= S_SERVE;
            end
          end else if (point_right) begin
            score_right <= right_next;
            serve_dir   <= 1'b0;
            if (right_next == WIN_VAL) begin
              winner      <= 2'b10;
              countdown   <= OVER_LD;
              match_state <= S_OVER;
            end else begin
              countdown   <= SERVE_LD;
              match_state <= S_SERVE;
            end
          end else if (pause_edge) begin
            match_state <= S_PAUSE;
          end
        end
        S_PAUSE: begin
          if (pause_edge) match_state <= S_PLAY;
        end
        S_OVER: begin
          if (frame_clk) begin
            if (countdown == 8'd1) begin
              countdown   <= 8'd0;
              match_state <= S_IDLE;
            end else begin
              countdown <= countdown - 8'd1;
            end
          end
        end
        default: begin
          countdown   <= 8'd0;
          match_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_match_sequencer.sv
// Directed bench for match_sequencer with WIN_SCORE=3, SERVE_FRAMES=2,
// OVER_FRAMES=3; expected values are hand-computed constants.
module tb_match_sequencer;

  localparam int SCORE_W = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic               frame_clk;
  logic               start_button;
  logic               pause_button;
  logic               point_left;
  logic               point_right;
  logic               start_game;
  logic               ball_hold;
  logic               serve_dir;
  logic [SCORE_W-1:0] score_left;
  logic [SCORE_W-1:0] score_right;
  logic [1:0]         winner;
  logic [2:0]         match_state;
  logic [7:0]         countdown;

  int checks = 0;
  int errors = 0;

  match_sequencer #(
    .WIN_SCORE    (3),
    .SERVE_FRAMES (2),
    .OVER_FRAMES  (3),
    .SCORE_W      (SCORE_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .frame_clk    (frame_clk),
    .start_button (start_button),
    .pause_button (pause_button),
    .point_left   (point_left),
    .point_right  (point_right),
    .start_game   (start_game),
    .ball_hold    (ball_hold),
    .serve_dir    (serve_dir),
    .score_left   (score_left),
    .score_right  (score_right),
    .winner       (winner),
    .match_state  (match_state),
    .countdown    (countdown)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic serve_to_play(input string tag);
    frame_clk = 1'b1;
    tick();
    tick();
    frame_clk = 1'b0;
    check({tag, "_state"}, match_state, 3'd2);
    check({tag, "_start_game"}, start_game, 1'b1);
  endtask

  initial begin
    reset        = 1'b1;
    frame_clk    = 1'b0;
    start_button = 1'b1;
    pause_button = 1'b0;
    point_left   = 1'b0;
    point_right  = 1'b0;

    #3;
    check("rst_state", match_state, 3'd0);
    check("rst_start_game", start_game, 1'b0);
    check("rst_ball_hold", ball_hold, 1'b1);
    check("rst_serve_dir", serve_dir, 1'b1);
    check("rst_score_l", score_left, 4'd0);
    check("rst_score_r", score_right, 4'd0);
    check("rst_winner", winner, 2'b00);
    check("rst_countdown", countdown, 8'd0);

    // Start held across reset release must not fire.
    tick();
    reset = 1'b0;
    tick();
    tick();
    check("held_start_idle", match_state, 3'd0);
    start_button = 1'b0;
    tick();
    start_button = 1'b1;
    tick();
    start_button = 1'b0;
    check("start_state", match_state, 3'd1);
    check("start_countdown", countdown, 8'd2);
    check("start_serve_dir", serve_dir, 1'b1);

    // Serve countdown.
    frame_clk = 1'b1;
    tick();
    check("serve_cd1", countdown, 8'd1);
    check("serve_still", match_state, 3'd1);
    check("serve_no_sg", start_game, 1'b0);
    tick();
    check("play_state", match_state, 3'd2);
    check("play_sg", start_game, 1'b1);
    check("play_hold", ball_hold, 1'b0);
    check("play_cd0", countdown, 8'd0);
    tick();
    frame_clk = 1'b0;
    check("play_sg_once", start_game, 1'b0);
    check("play_state2", match_state, 3'd2);

    // Right scores.
    point_right = 1'b1;
    tick();
    point_right = 1'b0;
    check("pr_score_r", score_right, 4'd1);
    check("pr_serve_dir", serve_dir, 1'b0);
    check("pr_state", match_state, 3'd1);
    check("pr_countdown", countdown, 8'd2);
    check("pr_hold", ball_hold, 1'b1);

    // Both points together.
    serve_to_play("both_pre");
    point_left  = 1'b1;
    point_right = 1'b1;
    tick();
    point_left  = 1'b0;
    point_right = 1'b0;
    check("both_score_l", score_left, 4'd0);
    check("both_score_r", score_right, 4'd1);
    check("both_state", match_state, 3'd1);
    check("both_serve_dir", serve_dir, 1'b0);
    check("both_countdown", countdown, 8'd2);

    // Pause edge coinciding with a point: point wins.
    serve_to_play("pp_pre");
    pause_button = 1'b1;
    point_left   = 1'b1;
    tick();
    point_left   = 1'b0;
    check("pp_score_l", score_left, 4'd1);
    check("pp_state", match_state, 3'd1);
    check("pp_serve_dir", serve_dir, 1'b1);
    pause_button = 1'b0;
    tick();
    check("pp_serve_hold", match_state, 3'd1);

    // Pause / resume.
    serve_to_play("pause_pre");
    pause_button = 1'b1;
    tick();
    pause_button = 1'b0;
    check("pause_state", match_state, 3'd3);
    check("pause_hold", ball_hold, 1'b1);
    point_left   = 1'b1;
    point_right  = 1'b1;
    frame_clk    = 1'b1;
    start_button = 1'b1;
    tick();
    point_left   = 1'b0;
    point_right  = 1'b0;
    frame_clk    = 1'b0;
    start_button = 1'b0;
    check("pause_ign_state", match_state, 3'd3);
    check("pause_ign_l", score_left, 4'd1);
    check("pause_ign_r", score_right, 4'd1);
    pause_button = 1'b1;
    tick();
    pause_button = 1'b0;
    check("resume_state", match_state, 3'd2);
    check("resume_no_sg", start_game, 1'b0);
    check("resume_hold", ball_hold, 1'b0);

    // Left runs to the win.
    point_left = 1'b1;
    tick();
    point_left = 1'b0;
    check("l2_score", score_left, 4'd2);
    check("l2_state", match_state, 3'd1);
    serve_to_play("l3_pre");
    point_left = 1'b1;
    tick();
    point_left = 1'b0;
    check("win_score_l", score_left, 4'd3);
    check("win_state", match_state, 3'd4);
    check("win_winner", winner, 2'b01);
    check("win_countdown", countdown, 8'd3);
    start_button = 1'b1;
    pause_button = 1'b1;
    tick();
    start_button = 1'b0;
    pause_button = 1'b0;
    check("over_ign_state", match_state, 3'd4);
    check("over_ign_cd", countdown, 8'd3);
    frame_clk = 1'b1;
    tick();
    check("over_cd2", countdown, 8'd2);
    tick();
    check("over_cd1", countdown, 8'd1);
    tick();
    frame_clk = 1'b0;
    check("over_idle", match_state, 3'd0);
    check("over_cd0", countdown, 8'd0);
    check("idle_held_l", score_left, 4'd3);
    check("idle_held_w", winner, 2'b01);

    // New match clears scores.
    start_button = 1'b1;
    tick();
    start_button = 1'b0;
    check("new_state", match_state, 3'd1);
    check("new_score_l", score_left, 4'd0);
    check("new_score_r", score_right, 4'd0);
    check("new_winner", winner, 2'b00);
    check("new_serve_dir", serve_dir, 1'b1);

    // Reset mid-serve, checked before the next clock edge.
    serve_to_play("rst2_pre");
    point_right = 1'b1;
    tick();
    point_right = 1'b0;
    check("rst2_pre_r", score_right, 4'd1);
    frame_clk = 1'b1;
    tick();
    frame_clk = 1'b0;
    check("rst2_pre_cd", countdown, 8'd1);
    #2;
    reset = 1'b1;
    #1;
    check("rst2_state", match_state, 3'd0);
    check("rst2_cd", countdown, 8'd0);
    check("rst2_score_r", score_right, 4'd0);
    check("rst2_hold", ball_hold, 1'b1);
    check("rst2_serve_dir", serve_dir, 1'b1);
    #1;
    reset = 1'b0;
    tick();
    check("rst2_after", match_state, 3'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/match_sequencer.md
# match_sequencer

Match-level controller that sequences the pong game state machine across a whole match. It handles idle, serve countdown, rally, pause, point scoring and game-over. It consumes point-scored pulses from the game datapath and produces the single-cycle `start_game` strobe, a ball-hold freeze, the serve direction, running scores and the winner for the display logic. It sits between the player buttons / frame timing and `game_sm`.

## Interface
- `WIN_SCORE`, 7: points needed to win; 1..2^SCORE_W-1.
- `SERVE_FRAMES`, 60: frame strobes between serve entry and rally start; 1..255.
- `OVER_FRAMES`, 180: frame strobes the game-over screen holds; 1..255.
- `SCORE_W`, 4: score counter width.

Ports:
- `clk` in 1: single system clock.
- `reset` in 1: asynchronous, active-high.
- `frame_clk` in 1: synchronous frame strobe; each cycle sampled high counts one frame.
- `start_button` in 1: level; rising edge detected internally.
- `pause_button` in 1: level; rising edge toggles pause.
- `point_left` in 1: pulse; left player scored.
- `point_right` in 1: pulse; right player scored.
- `start_game` out 1: one-cycle launch strobe to game_sm.
- `ball_hold` out 1: ball frozen.
- `serve_dir` out 1: 0 = serve toward left, 1 = toward right.
- `score_left` out SCORE_W: left player score.
- `score_right` out SCORE_W: right player score.
- `winner` out 2: 00 none, 01 left, 10 right.
- `match_state` out 3: 0 IDLE, 1 SERVE, 2 PLAY, 3 PAUSE, 4 OVER.
- `countdown` out 8: frames remaining in SERVE/OVER; 0 otherwise.

## Operation
- Reset values: match_state IDLE, start_game 0, ball_hold 1, serve_dir 1, scores 0, winner 00, countdown 0.
- Edge-detect history registers reset to 1. A button held through reset must be released before it can fire.
- `ball_hold` is decoded from state: 0 only in PLAY.
- **IDLE**
  - Scores and winner hold their last values for display.
  - A start edge clears the scores and winner, sets serve_dir=1, loads countdown=SERVE_FRAMES and moves to SERVE.
- **SERVE**
  - Each frame_clk decrements countdown.
  - At the strobe where countdown==1: go to PLAY, countdown=0, start_game=1 for that first PLAY cycle only.
  - Point and pause inputs are ignored.
- **PLAY**
  - point_left alone: score_left+1, serve_dir=1 (toward the conceding player).
  - point_right alone: score_right+1, serve_dir=0.
  - If the new score equals WIN_SCORE: go to OVER, winner=01 or 10, countdown=OVER_FRAMES.
  - Otherwise: go to SERVE, countdown=SERVE_FRAMES.
  - Both point inputs in the same cycle: no score change, serve_dir unchanged, go to SERVE.
  - Pause edge with no point: go to PAUSE.
  - Pause edge and point in the same cycle: the point wins and the pause edge is discarded.
- **PAUSE**
  - Points, start and frame_clk are ignored.
  - A pause edge returns to PLAY with no start_game pulse.
- **OVER**
  - frame_clk decrements countdown.
  - At the strobe where countdown==1: go to IDLE, countdown=0.
  - Start and pause are ignored.
- Start edges are ignored in every state except IDLE. Pause edges are ignored outside PLAY/PAUSE.
- Scores never exceed WIN_SCORE, so no wrap is possible.

## Timing
- All state and outputs are registered on the rising edge of `clk`. ball_hold is a decode of the state register.
- Start edge sampled at clock edge k: SERVE is visible after edge k. A frame_clk in cycle k is not counted.
- Serve latency is exactly SERVE_FRAMES frame strobes. start_game rises in the cycle PLAY first appears and lasts one clock.
- A point sampled at edge k: score, state and countdown are updated after edge k. A point is never lost in PLAY.
- Reset asserted at any time forces reset values immediately, independent of clk. Operation resumes from IDLE after deassertion.

## Test plan
- Bench settings: WIN_SCORE=3, SERVE_FRAMES=2, OVER_FRAMES=3.
- Held start through reset: start_button=1 across reset deassertion -> stays IDLE. Release, then press -> SERVE, countdown=2, serve_dir=1.
- Serve countdown: two frame_clk strobes in SERVE -> PLAY, start_game high exactly one cycle, ball_hold 0. A third strobe produces no further start_game.
- Point: point_right pulse in PLAY -> score_right=1, serve_dir=0, SERVE, countdown=2, ball_hold 1.
- Match win: left scores 3 rallies -> OVER, winner=01, countdown=3. Three strobes -> IDLE with score_left=3 held. Next start edge -> scores 0, winner 00.
- Simultaneous events:
  - point_left and point_right in the same cycle -> scores unchanged, SERVE, serve_dir unchanged.
  - pause edge and point_left in the same cycle -> score_left increments, no PAUSE.
- Pause and reset:
  - Pause edge in PLAY -> PAUSE, ball_hold 1, point pulses ignored. Second pause edge -> PLAY, start_game stays 0.
  - Reset asserted mid-SERVE -> IDLE, countdown 0, scores 0 without waiting for a clock.
